// File: rtl/uart_stream_ctrl.sv
// uart_stream_ctrl: TX/RX byte FIFOs bridging user logic to the UART core handshakes.
module uart_stream_ctrl #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic             uart_clk,
  input  logic             rst_n,
  input  logic             tx_wr_en,
  input  logic [7:0]       tx_wr_data,
  output logic             tx_full,
  output logic [TX_AW:0]   tx_level,
  output logic             tx_busy,
  input  logic             rx_rd_en,
  output logic [7:0]       rx_rd_data,
  output logic             rx_empty,
  output logic [RX_AW:0]   rx_level,
  output logic             rx_overflow,
  input  logic             rx_ovf_clr,
  output logic             uart_data_ready,
  output logic [7:0]       uart_data_in,
  input  logic             uart_transmit_end,
  input  logic             uart_rx_available,
  input  logic [7:0]       uart_data_out,
  output logic             uart_read
);
  localparam int TX_D = 1 << TX_AW;
  localparam int RX_D = 1 << RX_AW;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_BUSY} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;
  tx_state_t tx_st;
  rx_state_t rx_st;
  logic [7:0] tx_mem [TX_D];
  logic [7:0] rx_mem [RX_D];
  logic [TX_AW:0] tx_wp, tx_rp;
  logic [RX_AW:0] rx_wp, rx_rp;
  logic tx_empty, tx_push, tx_pop, rx_cap, rx_push, rx_pop;
  // level never exceeds depth, so its MSB alone marks full
  assign tx_level = tx_wp - tx_rp;
  assign tx_empty = tx_level == '0;
  assign tx_full  = tx_level[TX_AW];
  assign tx_pop   = (tx_st == T_IDLE) & ~tx_empty & uart_transmit_end;
  assign tx_push  = tx_wr_en & (~tx_full | tx_pop);
  assign tx_busy  = (tx_st != T_IDLE) | ~tx_empty;
  assign rx_level = rx_wp - rx_rp;
  assign rx_empty = rx_level == '0;
  assign rx_rd_data = rx_mem[rx_rp[RX_AW-1:0]];
  assign rx_cap  = (rx_st == R_IDLE) & uart_rx_available;
  assign rx_pop  = rx_rd_en & ~rx_empty;
  assign rx_push = rx_cap & (~rx_level[RX_AW] | rx_pop);
  always_ff @(posedge uart_clk) begin
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= tx_wr_data;
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= uart_data_out;
  end
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (TX_AW+1)'(1);
      if (tx_pop)  tx_rp <= tx_rp + (TX_AW+1)'(1);
      if (rx_push) rx_wp <= rx_wp + (RX_AW+1)'(1);
      if (rx_pop)  rx_rp <= rx_rp + (RX_AW+1)'(1);
    end
  end
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st <= T_IDLE;
      uart_data_ready <= 1'b0;
      uart_data_in <= '0;
    end else begin
      case (tx_st)
        T_IDLE: if (tx_pop) begin
          uart_data_in <= tx_mem[tx_rp[TX_AW-1:0]];
          uart_data_ready <= 1'b1;
          tx_st <= T_REQ;
        end
        T_REQ: if (!uart_transmit_end) begin
          uart_data_ready <= 1'b0;
          tx_st <= T_BUSY;
        end
        T_BUSY: if (uart_transmit_end) tx_st <= T_IDLE;
        default: tx_st <= T_IDLE;
      endcase
    end
  end
  // a dropped byte's set beats a same-cycle clear
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st <= R_IDLE;
      uart_read <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= (rx_cap & ~rx_push) | (rx_overflow & ~rx_ovf_clr);
      case (rx_st)
        R_IDLE: if (uart_rx_available) begin
          uart_read <= 1'b1;
          rx_st <= R_ACK;
        end
        R_ACK: begin
          uart_read <= 1'b0;
          rx_st <= R_WAIT;
        end
        R_WAIT: if (!uart_rx_available) rx_st <= R_IDLE;
        default: rx_st <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_stream_ctrl.sv
// tb_uart_stream_ctrl: scoreboard bench with a UART core model on both handshakes.
module tb_uart_stream_ctrl;
  logic uart_clk = 1'b0, rst_n = 1'b0;
  logic tx_wr_en = 1'b0, rx_rd_en = 1'b0, rx_ovf_clr = 1'b0;
  logic [7:0] tx_wr_data = '0, uart_data_out = '0;
  logic uart_transmit_end = 1'b1, uart_rx_available = 1'b0;
  logic tx_full, tx_busy, rx_empty, rx_overflow, uart_data_ready, uart_read;
  logic [4:0] tx_level, rx_level;
  logic [7:0] rx_rd_data, uart_data_in;
  int n_chk = 0, n_err = 0, hs_cnt = 0, ph = 0, hold = 0, hs0;
  bit model_en = 1'b0, te_idle = 1'b1, exp_ovf = 1'b0;
  logic [7:0] tx_q[$], rx_q[$];

  uart_stream_ctrl dut (
    .uart_clk(uart_clk), .rst_n(rst_n), .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
    .tx_full(tx_full), .tx_level(tx_level), .tx_busy(tx_busy), .rx_rd_en(rx_rd_en),
    .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .rx_overflow(rx_overflow), .rx_ovf_clr(rx_ovf_clr), .uart_data_ready(uart_data_ready),
    .uart_data_in(uart_data_in), .uart_transmit_end(uart_transmit_end),
    .uart_rx_available(uart_rx_available), .uart_data_out(uart_data_out), .uart_read(uart_read)
  );

  always #5 uart_clk = ~uart_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // UART TX model: accept a request, drop transmit_end for 3 cycles, then go idle
  always @(posedge uart_clk) begin
    #1;
    if (!model_en) begin
      uart_transmit_end = te_idle;
      ph = 0;
    end else if (ph == 0) begin
      if (uart_data_ready) begin
        hs_cnt++;
        if (tx_q.size() == 0) check("tx_extra_byte", 32'(tx_q.size()), 1);
        else check("tx_byte", uart_data_in, tx_q.pop_front());
        uart_transmit_end = 1'b0;
        ph = 1;
        hold = 3;
      end else uart_transmit_end = 1'b1;
    end else begin
      if (hold == 3) check("tx_dr_drop", uart_data_ready, 0);
      hold--;
      if (hold == 0) begin
        uart_transmit_end = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic tx_burst(input int n, input logic [7:0] first, input int acc);
    for (int i = 0; i < n; i++) begin
      @(negedge uart_clk);
      tx_wr_en = 1'b1;
      tx_wr_data = first + 8'(i);
      if (i < acc) tx_q.push_back(tx_wr_data);
    end
    @(negedge uart_clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 400 && tx_busy; i++) @(negedge uart_clk);
    check("tx_idle", tx_busy, 0);
  endtask

  task automatic wait_dr();
    for (int i = 0; i < 20 && !uart_data_ready; i++) @(negedge uart_clk);
    check("tx_req", uart_data_ready, 1);
  endtask

  task automatic rx_send(input logic [7:0] b, input bit with_pop, input int hold_cyc);
    int reads = 0;
    @(negedge uart_clk);
    if (with_pop) begin
      check("rx_pop_head", rx_rd_data, rx_q.pop_front());
      rx_rd_en = 1'b1;
    end
    if (with_pop || rx_q.size() < 16) rx_q.push_back(b);
    else exp_ovf = 1'b1;
    uart_rx_available = 1'b1;
    uart_data_out = b;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge uart_clk);
      rx_rd_en = 1'b0;
      if (uart_read) reads++;
    end
    uart_rx_available = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge uart_clk);
      if (uart_read) reads++;
    end
    check("rx_read_pulses", reads, 1);
  endtask

  task automatic rx_read();
    @(negedge uart_clk);
    check("rx_not_empty", rx_empty, 0);
    check("rx_data", rx_rd_data, rx_q.pop_front());
    rx_rd_en = 1'b1;
    @(negedge uart_clk);
    rx_rd_en = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_dr", uart_data_ready, 0);
    check("rst_din", uart_data_in, 0);
    check("rst_read", uart_read, 0);
    check("rst_ovf", rx_overflow, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_lvl", tx_level, 0);
    check("rst_rx_lvl", rx_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge uart_clk);
    check_reset_state();
    rst_n = 1'b1;
    // 1: single byte latency and handshake
    tx_burst(1, 8'h55, 1);
    check("tx_lat_dr_early", uart_data_ready, 0);
    check("tx_busy_queued", tx_busy, 1);
    @(negedge uart_clk);
    check("tx_lat_dr", uart_data_ready, 1);
    check("tx_lat_din", uart_data_in, 8'h55);
    hs0 = hs_cnt;
    model_en = 1'b1;
    wait_tx_idle();
    check("tx_hs_one", hs_cnt - hs0, 1);
    // 2: fill TX FIFO while the UART holds transmit_end low
    model_en = 1'b0;
    te_idle = 1'b0;
    tx_burst(17, 8'h01, 16);
    check("tx_full", tx_full, 1);
    check("tx_level_16", tx_level, 16);
    hs0 = hs_cnt;
    model_en = 1'b1;
    wait_tx_idle();
    check("tx_hs_16", hs_cnt - hs0, 16);
    check("tx_q_drained", tx_q.size(), 0);
    // 3: single received byte
    rx_send(8'hA5, 1'b0, 5);
    check("rx_level_1", rx_level, 1);
    rx_read();
    check("rx_empty_after", rx_empty, 1);
    // 4: overflow on the 17th byte, then clear
    for (int i = 0; i < 17; i++) rx_send(8'h10 + 8'(i), 1'b0, 1);
    check("rx_level_full", rx_level, 16);
    check("rx_ovf_set", rx_overflow, exp_ovf);
    @(negedge uart_clk);
    rx_ovf_clr = 1'b1;
    exp_ovf = 1'b0;
    @(negedge uart_clk);
    rx_ovf_clr = 1'b0;
    check("rx_ovf_clr", rx_overflow, exp_ovf);
    // 5: capture into a full FIFO while the user pops on the same edge
    rx_send(8'hEE, 1'b1, 1);
    check("rx_level_hold", rx_level, 16);
    check("rx_no_ovf", rx_overflow, exp_ovf);
    while (rx_q.size() > 0) rx_read();
    check("rx_drained", rx_empty, 1);
    // 6: reset in the middle of a request
    rx_send(8'h77, 1'b0, 1);
    model_en = 1'b0;
    te_idle = 1'b1;
    tx_burst(1, 8'hC3, 1);
    wait_dr();
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    tx_q.delete();
    rx_q.delete();
    te_idle = 1'b0;
    repeat (2) @(negedge uart_clk);
    rst_n = 1'b1;
    tx_burst(1, 8'h3C, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge uart_clk);
      check("tx_hold_no_te", uart_data_ready, 0);
    end
    te_idle = 1'b1;
    wait_dr();
    check("tx_after_rst_din", uart_data_in, 8'h3C);
    hs0 = hs_cnt;
    model_en = 1'b1;
    wait_tx_idle();
    check("tx_hs_after_rst", hs_cnt - hs0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
